// File: rtl/scr1_pipe_mprf_wb_arb_if.sv
// Write-back arbiter bus bundle: EXU/LSU side is master, arbiter is slave.
// SCR1_MPRF_WB_FWD_EN adds the FIFO forwarding outputs; SCR1_RVE_EXT narrows AW.
`ifdef SCR1_RVE_EXT
  `define SCR1_WB_ARB_AW_DFLT 4
`else
  `define SCR1_WB_ARB_AW_DFLT 5
`endif

interface scr1_pipe_mprf_wb_arb_if #(
    parameter int XLEN = 32,
    parameter int AW   = `SCR1_WB_ARB_AW_DFLT
);
    logic            exu_wb_vld;
    logic            exu_wb_rdy;
    logic [AW-1:0]   exu_wb_rd;
    logic [XLEN-1:0] exu_wb_data;
    logic            lsu_issue_vld;
    logic [AW-1:0]   lsu_issue_rd;
    logic            lsu_ret_vld;
    logic            lsu_ret_rdy;
    logic [AW-1:0]   lsu_ret_rd;
    logic [XLEN-1:0] lsu_ret_data;
    logic [AW-1:0]   hz_rs1_addr;
    logic [AW-1:0]   hz_rs2_addr;
    logic            hz_rs1;
    logic            hz_rs2;
    logic            mprf_w_req;
    logic [AW-1:0]   mprf_rd_addr;
    logic [XLEN-1:0] mprf_rd_data;
    logic            sb_busy;
`ifdef SCR1_MPRF_WB_FWD_EN
    logic            fwd_rs1_vld;
    logic [XLEN-1:0] fwd_rs1_data;
    logic            fwd_rs2_vld;
    logic [XLEN-1:0] fwd_rs2_data;
`endif

    modport slave (
        input  exu_wb_vld, exu_wb_rd, exu_wb_data,
        input  lsu_issue_vld, lsu_issue_rd,
        input  lsu_ret_vld, lsu_ret_rd, lsu_ret_data,
        input  hz_rs1_addr, hz_rs2_addr,
        output exu_wb_rdy, lsu_ret_rdy, hz_rs1, hz_rs2,
        output mprf_w_req, mprf_rd_addr, mprf_rd_data, sb_busy
`ifdef SCR1_MPRF_WB_FWD_EN
       ,output fwd_rs1_vld, fwd_rs1_data, fwd_rs2_vld, fwd_rs2_data
`endif
    );

    modport master (
        output exu_wb_vld, exu_wb_rd, exu_wb_data,
        output lsu_issue_vld, lsu_issue_rd,
        output lsu_ret_vld, lsu_ret_rd, lsu_ret_data,
        output hz_rs1_addr, hz_rs2_addr,
        input  exu_wb_rdy, lsu_ret_rdy, hz_rs1, hz_rs2,
        input  mprf_w_req, mprf_rd_addr, mprf_rd_data, sb_busy
`ifdef SCR1_MPRF_WB_FWD_EN
       ,input  fwd_rs1_vld, fwd_rs1_data, fwd_rs2_vld, fwd_rs2_data
`endif
    );
endinterface

// File: rtl/scr1_pipe_mprf_wb_arb.sv
// MPRF write-port arbiter (LSU return FIFO vs EXU) with pending-load scoreboard.
// Optional SCR1_MPRF_WB_FWD_EN forwards buffered load data to hazard queries.
module scr1_pipe_mprf_wb_arb #(
    parameter int XLEN         = 32,
    parameter int AW           = `SCR1_WB_ARB_AW_DFLT,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    scr1_pipe_mprf_wb_arb_if.slave  io_wb
);
    localparam int AIW  = $clog2(FIFO_DEPTH);
    localparam int PW   = AIW + 1;
    localparam int NREG = 1 << AW;
    localparam int SW   = $clog2(STARVE_LIMIT + 1);

    logic [AW-1:0]   r_fifo_rd   [FIFO_DEPTH];
    logic [XLEN-1:0] r_fifo_data [FIFO_DEPTH];
    logic [PW-1:0]   r_wptr, r_rptr;
    logic [NREG-1:0] r_sb;
    logic [SW-1:0]   r_starve;

    logic [PW-1:0]   w_cnt;
    logic            w_empty, w_full, w_enq, w_waw, w_starved;
    logic            w_gnt_exu, w_gnt_fifo;
    logic [AW-1:0]   w_head_rd;
    logic [XLEN-1:0] w_head_data;
    logic [NREG-1:0] w_sb_set, w_sb_clr;

    assign w_cnt       = r_wptr - r_rptr;
    assign w_empty     = (r_wptr == r_rptr);
    assign w_full      = (w_cnt == PW'(FIFO_DEPTH));
    assign w_enq       = io_wb.lsu_ret_vld & ~w_full;
    assign w_head_rd   = r_fifo_rd[r_rptr[AIW-1:0]];
    assign w_head_data = r_fifo_data[r_rptr[AIW-1:0]];
    assign w_waw       = io_wb.exu_wb_vld & r_sb[io_wb.exu_wb_rd];
    assign w_starved   = (r_starve == SW'(STARVE_LIMIT));

    // rst_n gates the grants so nothing reaches the MPRF while reset is held
    assign w_gnt_exu  = rst_n & io_wb.exu_wb_vld & ~w_waw & (w_empty | w_starved);
    assign w_gnt_fifo = rst_n & ~w_empty & ~w_gnt_exu;

    assign io_wb.exu_wb_rdy  = w_gnt_exu;
    assign io_wb.lsu_ret_rdy = ~w_full;
    assign io_wb.sb_busy     = (|r_sb) | ~w_empty;

    always_comb begin
        io_wb.mprf_w_req   = 1'b0;
        io_wb.mprf_rd_addr = '0;
        io_wb.mprf_rd_data = '0;
        if (w_gnt_fifo) begin
            io_wb.mprf_w_req   = |w_head_rd;
            io_wb.mprf_rd_addr = w_head_rd;
            io_wb.mprf_rd_data = w_head_data;
        end else if (w_gnt_exu) begin
            io_wb.mprf_w_req   = |io_wb.exu_wb_rd;
            io_wb.mprf_rd_addr = io_wb.exu_wb_rd;
            io_wb.mprf_rd_data = io_wb.exu_wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_fifo_rd[r_wptr[AIW-1:0]]   <= io_wb.lsu_ret_rd;
            r_fifo_data[r_wptr[AIW-1:0]] <= io_wb.lsu_ret_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_enq)      r_wptr <= r_wptr + PW'(1);
            if (w_gnt_fifo) r_rptr <= r_rptr + PW'(1);
        end
    end

    // set after clear so a same-cycle re-issue keeps the bit; bit 0 never held
    assign w_sb_clr = w_gnt_fifo          ? (NREG'(1) << w_head_rd)          : '0;
    assign w_sb_set = io_wb.lsu_issue_vld ? (NREG'(1) << io_wb.lsu_issue_rd) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sb <= '0;
        else        r_sb <= ((r_sb & ~w_sb_clr) | w_sb_set) & ~NREG'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                     r_starve <= '0;
        else if (!io_wb.exu_wb_vld || w_gnt_exu)        r_starve <= '0;
        else if (w_gnt_fifo && !w_waw && !w_starved)    r_starve <= r_starve + SW'(1);
    end

`ifdef SCR1_MPRF_WB_FWD_EN
    logic            w_fwd1_vld, w_fwd2_vld;
    logic [XLEN-1:0] w_fwd1_data, w_fwd2_data;

    // scan oldest to youngest so the youngest matching entry wins
    always_comb begin
        logic [AIW-1:0] idx;
        idx         = '0;
        w_fwd1_vld  = 1'b0;
        w_fwd1_data = '0;
        w_fwd2_vld  = 1'b0;
        w_fwd2_data = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            idx = r_rptr[AIW-1:0] + AIW'(i);
            if (PW'(i) < w_cnt) begin
                if (|io_wb.hz_rs1_addr && r_fifo_rd[idx] == io_wb.hz_rs1_addr) begin
                    w_fwd1_vld  = 1'b1;
                    w_fwd1_data = r_fifo_data[idx];
                end
                if (|io_wb.hz_rs2_addr && r_fifo_rd[idx] == io_wb.hz_rs2_addr) begin
                    w_fwd2_vld  = 1'b1;
                    w_fwd2_data = r_fifo_data[idx];
                end
            end
        end
    end

    assign io_wb.fwd_rs1_vld  = w_fwd1_vld;
    assign io_wb.fwd_rs1_data = w_fwd1_data;
    assign io_wb.fwd_rs2_vld  = w_fwd2_vld;
    assign io_wb.fwd_rs2_data = w_fwd2_data;
    assign io_wb.hz_rs1 = r_sb[io_wb.hz_rs1_addr] & ~w_fwd1_vld;
    assign io_wb.hz_rs2 = r_sb[io_wb.hz_rs2_addr] & ~w_fwd2_vld;
`else
    assign io_wb.hz_rs1 = r_sb[io_wb.hz_rs1_addr];
    assign io_wb.hz_rs2 = r_sb[io_wb.hz_rs2_addr];
`endif
endmodule
